stopwatch_key_ctrl: RTL

Upstream control stage for the 3-digit BCD stopwatch counter/display. It debounces two active-low pushbuttons (start/stop, clear) and runs an IDLE/RUN/PAUSE state machine. It produces a single-cycle count-enable strobe every TICK_DIV clocks while running, plus a single-cycle clear strobe. Everything runs on one clock with clock-enable strobes, so the counter stage needs no derived clocks.

---
 rtl/stopwatch_pkg.sv | 14 +
 rtl/key_debounce.sv | 62 ++++++
 rtl/stopwatch_key_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control stage: state encoding and
// debounce counter sizing used by both the top level and the key debouncer.
package stopwatch_pkg;

    typedef logic [1:0] sw_state_t;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;

    // Mismatch counter width; STABLE_CNT is limited to 1..255.
    localparam int DBC_CNT_W = 8;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton path: 2-flop synchronizer, sample-tick driven mismatch counter
// and a single-cycle press pulse on an accepted released->pressed transition.
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int STABLE_CNT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_tick,
    input  logic key_n,
    output logic press
);

    localparam logic [DBC_CNT_W-1:0] CNT_LAST = DBC_CNT_W'(STABLE_CNT - 1);

    logic                 sync1_q, sync2_q;
    logic                 stable_q, stable_d;
    logic [DBC_CNT_W-1:0] cnt_q, cnt_d;
    logic                 press_q, press_d;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        stable_d = stable_q;
        cnt_d    = cnt_q;
        press_d  = 1'b0;
        if (sample_tick) begin
            if (sync2_q != stable_q) begin
                if (cnt_q == CNT_LAST) begin
                    stable_d = ~stable_q;
                    cnt_d    = '0;
                    press_d  = stable_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    // Sync flops idle high so a released key never looks like a press after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= key_n;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/stopwatch_key_ctrl.sv
// Stopwatch control: debounced start/stop and clear keys drive an IDLE/RUN/PAUSE
// FSM producing a COUNT_EN strobe every TICK_DIV clocks while running, plus CLR.
module stopwatch_key_ctrl
    import stopwatch_pkg::*;
#(
    parameter int SAMPLE_DIV = 10000,
    parameter int STABLE_CNT = 8,
    parameter int TICK_DIV   = 1000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       KEY_SS_N,
    input  logic       KEY_CLR_N,
    output logic       COUNT_EN,
    output logic       CLR,
    output logic       RUN,
    output logic [1:0] STATE,
    output logic       SS_PRESS,
    output logic       CLR_PRESS
);

    localparam int PRE_W  = $clog2(SAMPLE_DIV);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(SAMPLE_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [PRE_W-1:0]  prescale_q, prescale_d;
    logic              sample_tick;
    logic              ss_press, clr_press;
    sw_state_t         state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              clr_q, clr_d;
    logic              count_en;

    assign sample_tick = (prescale_q == PRE_LAST);
    assign prescale_d  = sample_tick ? '0 : prescale_q + 1'b1;

    key_debounce #(.STABLE_CNT(STABLE_CNT)) u_ss_key (
        .clk         (CLK),
        .reset       (RESET),
        .sample_tick (sample_tick),
        .key_n       (KEY_SS_N),
        .press       (ss_press)
    );

    key_debounce #(.STABLE_CNT(STABLE_CNT)) u_clr_key (
        .clk         (CLK),
        .reset       (RESET),
        .sample_tick (sample_tick),
        .key_n       (KEY_CLR_N),
        .press       (clr_press)
    );

    // Clear wins over start/stop wherever clear is accepted; RUN ignores clear.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        clr_d    = 1'b0;
        count_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tick_d = '0;
                if (clr_press) begin
                    clr_d = 1'b1;
                end else if (ss_press) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A pause landing on the terminal count holds it, so the strobe fires on resume.
                if (ss_press) begin
                    state_d = ST_PAUSE;
                end else if (tick_q == TICK_LAST) begin
                    count_en = 1'b1;
                    tick_d   = '0;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (clr_press) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                    tick_d  = '0;
                end else if (ss_press) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tick_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prescale_q <= '0;
            state_q    <= ST_IDLE;
            tick_q     <= '0;
            clr_q      <= 1'b0;
        end else begin
            prescale_q <= prescale_d;
            state_q    <= state_d;
            tick_q     <= tick_d;
            clr_q      <= clr_d;
        end
    end

    assign COUNT_EN  = count_en;
    assign CLR       = clr_q;
    assign RUN       = (state_q == ST_RUN);
    assign STATE     = state_q;
    assign SS_PRESS  = ss_press;
    assign CLR_PRESS = clr_press;

endmodule
